// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and types for the FIFO stream reader: skid depth and
// occupancy encodings used by the top and its skid buffer.
package fifo_stream_reader_pkg;

    localparam int SKID_DEPTH = 2;
    localparam int COUNT_W    = 2;

    typedef enum logic [COUNT_W-1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_e;

    // The skid can accept a new word whenever it is not full.
    function automatic logic skid_has_room(input logic [COUNT_W-1:0] count);
        return count < COUNT_W'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO read port, flush control and the downstream valid/ready
// stream seen by the reader.
interface fifo_stream_reader_if
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 2
);
    logic [DATA_WIDTH-1:0] io_fifo_dout;
    logic                  io_fifo_empty;
    logic                  io_fifo_pop;
    logic                  io_flush;
    logic [DATA_WIDTH-1:0] io_deq_data;
    logic                  io_deq_valid;
    logic                  io_deq_ready;
    logic [COUNT_W-1:0]    io_count;

    modport master (
        output io_fifo_dout, io_fifo_empty, io_flush, io_deq_ready,
        input  io_fifo_pop, io_deq_data, io_deq_valid, io_count
    );

    modport slave (
        input  io_fifo_dout, io_fifo_empty, io_flush, io_deq_ready,
        output io_fifo_pop, io_deq_data, io_deq_valid, io_count
    );
endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry skid register pair with occupancy count. Entry 0 is always the
// stream head; entry 1 only holds a word while the consumer stalls.
module fifo_stream_reader_skid_buf2
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] head,
    output logic [COUNT_W-1:0]    count
);
    cnt_e                  state_reg, state_next;
    logic [DATA_WIDTH-1:0] entry_reg  [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] entry_next [SKID_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= CNT_EMPTY;
        else        state_reg <= state_next;
    end

    generate
        for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) entry_reg[gi] <= '0;
                else        entry_reg[gi] <= entry_next[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        entry_next = entry_reg;
        if (clear) begin
            // Entries are kept; only the occupancy is dropped.
            state_next = CNT_EMPTY;
        end else begin
            case (state_reg)
                CNT_EMPTY: begin
                    if (load) begin
                        entry_next[0] = load_data;
                        state_next    = CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (load && shift) begin
                        entry_next[0] = load_data;
                    end else if (load) begin
                        entry_next[1] = load_data;
                        state_next    = CNT_FULL;
                    end else if (shift) begin
                        state_next = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (shift) begin
                        entry_next[0] = entry_reg[1];
                        state_next    = CNT_ONE;
                    end
                end
                default: state_next = CNT_EMPTY;
            endcase
        end
    end

    assign head  = entry_reg[0];
    assign count = state_reg;
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a push/pop FIFO into a valid/ready stream through a 2-entry skid
// buffer so consumer backpressure never stalls the pop path combinationally.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 2
) (
    input logic                  clk,
    input logic                  reset,
    fifo_stream_reader_if.slave  bus
);
    logic               pop;
    logic               valid;
    logic               deq;
    logic [COUNT_W-1:0] count;

    // Pop is masked during reset so a non-empty FIFO is not advanced while held.
    assign pop   = reset & ~bus.io_fifo_empty & ~bus.io_flush & skid_has_room(count);
    assign valid = (count != '0) & ~bus.io_flush;
    assign deq   = valid & bus.io_deq_ready;

    fifo_stream_reader_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (pop),
        .load_data (bus.io_fifo_dout),
        .shift     (deq),
        .clear     (bus.io_flush),
        .head      (bus.io_deq_data),
        .count     (count)
    );

    assign bus.io_fifo_pop  = pop;
    assign bus.io_deq_valid = valid;
    assign bus.io_count     = count;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed table-driven bench for fifo_stream_reader with a small FIFO model
// feeding dout/empty.
module tb_fifo_stream_reader;
    import fifo_stream_reader_pkg::*;

    localparam int DW = 2;

    logic clk;
    logic reset;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string          name;
        int             n_push;
        logic [DW-1:0]  w0, w1, w2;
        logic           ready;
        logic           flush;
        logic           e_pop;
        logic           e_valid;
        logic [DW-1:0]  e_data;
        logic [1:0]     e_count;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] fifo_mem [64];
    int            rd_ptr;
    int            wr_ptr;
    int            n_vec;
    int            n_miss;

    function automatic vec_t mk(input string name, input int n_push,
                                input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                input logic [DW-1:0] w2, input logic ready,
                                input logic flush, input logic e_pop,
                                input logic e_valid, input logic [DW-1:0] e_data,
                                input logic [1:0] e_count);
        vec_t v;
        v.name = name; v.n_push = n_push; v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.ready = ready; v.flush = flush; v.e_pop = e_pop; v.e_valid = e_valid;
        v.e_data = e_data; v.e_count = e_count;
        return v;
    endfunction

    task automatic drive_fifo();
        bus.io_fifo_empty = (rd_ptr == wr_ptr);
        bus.io_fifo_dout  = (rd_ptr == wr_ptr) ? '0 : fifo_mem[rd_ptr];
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic check(input string nm, input string field, input int got, input int exp);
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, field, got, exp);
        end
    endtask

    // Called just after a negedge: drive inputs, check, then cross one posedge.
    task automatic apply(input vec_t v);
        logic p;
        if (v.n_push > 0) push(v.w0);
        if (v.n_push > 1) push(v.w1);
        if (v.n_push > 2) push(v.w2);
        bus.io_deq_ready = v.ready;
        bus.io_flush     = v.flush;
        drive_fifo();
        #1;
        n_vec++;
        check(v.name, "pop",   int'(bus.io_fifo_pop),  int'(v.e_pop));
        check(v.name, "valid", int'(bus.io_deq_valid), int'(v.e_valid));
        check(v.name, "count", int'(bus.io_count),     int'(v.e_count));
        if (v.e_valid)
            check(v.name, "data", int'(bus.io_deq_data), int'(v.e_data));
        $display("vec %-6s rdy=%0b fl=%0b pop=%0b valid=%0b data=%0d count=%0d",
                 v.name, v.ready, v.flush, bus.io_fifo_pop, bus.io_deq_valid,
                 bus.io_deq_data, bus.io_count);
        p = bus.io_fifo_pop;
        @(posedge clk);
        if (p) rd_ptr++;
        #1 drive_fifo();
        @(negedge clk);
    endtask

    initial begin
        rd_ptr = 0; wr_ptr = 0; n_vec = 0; n_miss = 0;
        reset = 1'b0;
        bus.io_deq_ready = 1'b0;
        bus.io_flush     = 1'b0;
        drive_fifo();

        // streaming, ready held high
        vecs.push_back(mk("st0", 3, 2'd1, 2'd2, 2'd3, 1, 0, 1, 0, 2'd0, 2'd0));
        vecs.push_back(mk("st1", 0, 0, 0, 0,          1, 0, 1, 1, 2'd1, 2'd1));
        vecs.push_back(mk("st2", 0, 0, 0, 0,          1, 0, 1, 1, 2'd2, 2'd1));
        vecs.push_back(mk("st3", 0, 0, 0, 0,          1, 0, 0, 1, 2'd3, 2'd1));
        vecs.push_back(mk("st4", 0, 0, 0, 0,          1, 0, 0, 0, 2'd0, 2'd0));
        // backpressure then release
        vecs.push_back(mk("bp0", 3, 2'd1, 2'd2, 2'd3, 0, 0, 1, 0, 2'd0, 2'd0));
        vecs.push_back(mk("bp1", 0, 0, 0, 0,          0, 0, 1, 1, 2'd1, 2'd1));
        vecs.push_back(mk("bp2", 0, 0, 0, 0,          0, 0, 0, 1, 2'd1, 2'd2));
        vecs.push_back(mk("bp3", 0, 0, 0, 0,          0, 0, 0, 1, 2'd1, 2'd2));
        vecs.push_back(mk("bp4", 0, 0, 0, 0,          1, 0, 0, 1, 2'd1, 2'd2));
        vecs.push_back(mk("bp5", 0, 0, 0, 0,          1, 0, 1, 1, 2'd2, 2'd1));
        vecs.push_back(mk("bp6", 0, 0, 0, 0,          1, 0, 0, 1, 2'd3, 2'd1));
        vecs.push_back(mk("bp7", 0, 0, 0, 0,          1, 0, 0, 0, 2'd0, 2'd0));
        // flush with the skid full of 2,3; the FIFO still holds 0
        vecs.push_back(mk("fl0", 3, 2'd2, 2'd3, 2'd0, 0, 0, 1, 0, 2'd0, 2'd0));
        vecs.push_back(mk("fl1", 0, 0, 0, 0,          0, 0, 1, 1, 2'd2, 2'd1));
        vecs.push_back(mk("fl2", 0, 0, 0, 0,          0, 0, 0, 1, 2'd2, 2'd2));
        vecs.push_back(mk("fl3", 0, 0, 0, 0,          1, 1, 0, 0, 2'd0, 2'd2));
        vecs.push_back(mk("fl4", 0, 0, 0, 0,          1, 0, 1, 0, 2'd0, 2'd0));
        vecs.push_back(mk("fl5", 0, 0, 0, 0,          1, 0, 0, 1, 2'd0, 2'd1));
        vecs.push_back(mk("fl6", 0, 0, 0, 0,          1, 0, 0, 0, 2'd0, 2'd0));
        // simultaneous pop and dequeue at count 1
        vecs.push_back(mk("sm0", 1, 2'd1, 0, 0,       0, 0, 1, 0, 2'd0, 2'd0));
        vecs.push_back(mk("sm1", 1, 2'd3, 0, 0,       1, 0, 1, 1, 2'd1, 2'd1));
        vecs.push_back(mk("sm2", 0, 0, 0, 0,          1, 0, 0, 1, 2'd3, 2'd1));
        vecs.push_back(mk("sm3", 0, 0, 0, 0,          1, 0, 0, 0, 2'd0, 2'd0));

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        check("rst", "pop",   int'(bus.io_fifo_pop),  0);
        check("rst", "valid", int'(bus.io_deq_valid), 0);
        check("rst", "data",  int'(bus.io_deq_data),  0);
        check("rst", "count", int'(bus.io_count),     0);
        $display("vec rst    pop=%0b valid=%0b data=%0d count=%0d",
                 bus.io_fifo_pop, bus.io_deq_valid, bus.io_deq_data, bus.io_count);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) apply(vecs[i]);

        // empty FIFO for 10 cycles with ready toggling
        for (int i = 0; i < 10; i++)
            apply(mk($sformatf("em%0d", i), 0, 0, 0, 0, logic'(i % 2), 0, 0, 0, 2'd0, 2'd0));

        // async reset while the skid is full and the FIFO still has a word
        apply(mk("ar0", 3, 2'd1, 2'd2, 2'd3, 0, 0, 1, 0, 2'd0, 2'd0));
        apply(mk("ar1", 0, 0, 0, 0,          0, 0, 1, 1, 2'd1, 2'd1));
        #2 reset = 1'b0;
        #1;
        n_vec++;
        check("arst", "pop",   int'(bus.io_fifo_pop),  0);
        check("arst", "valid", int'(bus.io_deq_valid), 0);
        check("arst", "count", int'(bus.io_count),     0);
        check("arst", "data",  int'(bus.io_deq_data),  0);
        $display("vec arst   pop=%0b valid=%0b data=%0d count=%0d",
                 bus.io_fifo_pop, bus.io_deq_valid, bus.io_deq_data, bus.io_count);
        @(negedge clk);
        rd_ptr = wr_ptr;
        drive_fifo();
        reset = 1'b1;
        @(negedge clk);
        apply(mk("ar2", 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0));
        apply(mk("ar3", 1, 2'd2, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0));
        apply(mk("ar4", 0, 0, 0, 0, 1, 0, 0, 1, 2'd2, 2'd1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
